// File: rtl/dec_stamp_fifo.sv
// +--------------------------------------------------------------------------+
// | dec_stamp_fifo: microsecond-timestamped FIFO of decoded words for SPI.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module dec_stamp_fifo #(
  parameter int          CLK_PER_US = 100,
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [31:0] EMPTY_WORD = 32'hFFFFFFFF
) (
  input  logic                  clk2x,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [31:0]           dec_data,
  input  logic                  rd_req,
  input  logic                  clr_ovf,
  output logic [31:0]           decPack,
  output logic [31:0]           timeUs,
  output logic                  pkt_avail,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int                PTR_W    = DEPTH_LOG2;
  localparam int                LVL_W    = DEPTH_LOG2 + 1;
  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam int                PRE_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_PER_US - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);

  logic [PRE_W-1:0] prescaler;
  logic [31:0]      us_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      data_mem [DEPTH];
  logic [31:0]      time_mem [DEPTH];

  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [LVL_W-1:0] level_next;
  logic [31:0]      head_data;
  logic [31:0]      head_time;

  always_comb begin
    full        = (level == FULL_LVL);
    pop_ok      = rd_req && (level != '0);
    // A full FIFO still accepts a push when the same edge frees a slot.
    push_ok     = dec_valid && (!full || rd_req);
    drop        = dec_valid && full && !rd_req;
    rd_ptr_next = rd_ptr + PTR_W'(pop_ok);
    level_next  = level + LVL_W'(push_ok) - LVL_W'(pop_ok);
    head_data   = EMPTY_WORD;
    head_time   = EMPTY_WORD;
    if (level_next != '0) begin
      if (push_ok && (wr_ptr == rd_ptr_next)) begin
        head_data = dec_data;
        head_time = us_cnt;
      end else begin
        head_data = data_mem[rd_ptr_next];
        head_time = time_mem[rd_ptr_next];
      end
    end
  end

  always_ff @(negedge clk2x) begin
    if (push_ok) begin
      data_mem[wr_ptr] <= dec_data;
      time_mem[wr_ptr] <= us_cnt;
    end
  end

  always_ff @(negedge clk2x) begin
    if (rst) begin
      prescaler <= '0;
      us_cnt    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_avail <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      decPack   <= EMPTY_WORD;
      timeUs    <= EMPTY_WORD;
    end else begin
      if (prescaler == PRE_MAX) begin
        prescaler <= '0;
        us_cnt    <= us_cnt + 32'd1;
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end

      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_ptr_next;
      level     <= level_next;
      pkt_avail <= (level_next != '0);
      decPack   <= head_data;
      timeUs    <= head_time;

      // A drop on the clearing edge wins and restarts the count at one.
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf)               drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dec_stamp_fifo.sv
// +--------------------------------------------------------------------------+
// | tb_dec_stamp_fifo: directed vector bench for dec_stamp_fifo.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dec_stamp_fifo;

  localparam logic [31:0] E = 32'hFFFFFFFF;

  logic        clk2x = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [31:0] dec_data;
  logic        rd_req;
  logic        clr_ovf;
  logic [31:0] decPack;
  logic [31:0] timeUs;
  logic        pkt_avail;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  dec_stamp_fifo #(
    .CLK_PER_US (4),
    .DEPTH_LOG2 (2),
    .EMPTY_WORD (32'hFFFFFFFF)
  ) dut (
    .clk2x     (clk2x),
    .rst       (rst),
    .dec_valid (dec_valid),
    .dec_data  (dec_data),
    .rd_req    (rd_req),
    .clr_ovf   (clr_ovf),
    .decPack   (decPack),
    .timeUs    (timeUs),
    .pkt_avail (pkt_avail),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk2x = ~clk2x;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        c;
    logic [31:0] ed;
    logic [31:0] et;
    logic [2:0]  el;
    logic        eo;
    logic [7:0]  edc;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One active (negative) edge with the given strobes; returns mid-phase.
  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic c);
    dec_valid = v;
    dec_data  = d;
    rd_req    = r;
    clr_ovf   = c;
    @(negedge clk2x);
    #2;
    dec_valid = 1'b0;
    rd_req    = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ed, input logic [31:0] et,
                         input logic [2:0] el, input logic eo, input logic [7:0] edc);
    chk({tag, ".decPack"},   decPack,   ed);
    chk({tag, ".timeUs"},    timeUs,    et);
    chk({tag, ".level"},     32'(level), 32'(el));
    chk({tag, ".pkt_avail"}, 32'(pkt_avail), 32'(el != 3'd0));
    chk({tag, ".overflow"},  32'(overflow), 32'(eo));
    chk({tag, ".drop_cnt"},  32'(drop_cnt), 32'(edc));
  endtask

  initial begin
    rst = 1'b1; dec_valid = 1'b0; dec_data = '0; rd_req = 1'b0; clr_ovf = 1'b0;

    // Vector n runs on edge n+1 after reset, so a push stamps floor(n/4).
    vt[0]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 32'hA1, 32'd0, 3'd1, 1'b0, 8'd0};
    vt[1]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 32'hA1, 32'd0, 3'd2, 1'b0, 8'd0};
    vt[2]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 32'hA1, 32'd0, 3'd3, 1'b0, 8'd0};
    vt[3]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 32'hA1, 32'd0, 3'd4, 1'b0, 8'd0};
    vt[4]  = '{1'b1, 32'hA5, 1'b0, 1'b0, 32'hA1, 32'd0, 3'd4, 1'b1, 8'd1};
    vt[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hA2, 32'd0, 3'd3, 1'b1, 8'd1};
    vt[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hA3, 32'd0, 3'd2, 1'b1, 8'd1};
    vt[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hA4, 32'd0, 3'd1, 1'b1, 8'd1};
    vt[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, E,      E,     3'd0, 1'b1, 8'd1};
    vt[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, E,      E,     3'd0, 1'b1, 8'd1};
    vt[10] = '{1'b1, 32'hC0, 1'b1, 1'b1, 32'hC0, 32'd2, 3'd1, 1'b0, 8'd0};
    vt[11] = '{1'b1, 32'hB1, 1'b0, 1'b0, 32'hC0, 32'd2, 3'd2, 1'b0, 8'd0};
    vt[12] = '{1'b1, 32'hB2, 1'b0, 1'b0, 32'hC0, 32'd2, 3'd3, 1'b0, 8'd0};
    vt[13] = '{1'b1, 32'hB3, 1'b0, 1'b0, 32'hC0, 32'd2, 3'd4, 1'b0, 8'd0};
    vt[14] = '{1'b1, 32'hB0, 1'b1, 1'b0, 32'hB1, 32'd2, 3'd4, 1'b0, 8'd0};
    vt[15] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hB2, 32'd3, 3'd3, 1'b0, 8'd0};
    vt[16] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hB3, 32'd3, 3'd2, 1'b0, 8'd0};
    vt[17] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hB0, 32'd3, 3'd1, 1'b0, 8'd0};
    vt[18] = '{1'b0, 32'h0,  1'b1, 1'b0, E,      E,     3'd0, 1'b0, 8'd0};
    vt[19] = '{1'b0, 32'h0,  1'b0, 1'b0, E,      E,     3'd0, 1'b0, 8'd0};

    // Reset state and idle timer
    do_reset();
    chk_all("reset", E, E, 3'd0, 1'b0, 8'd0);
    chk("reset.us_cnt", dut.us_cnt, 32'd0);
    for (int i = 0; i < 1000; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk_all("idle", E, E, 3'd0, 1'b0, 8'd0);
    chk("idle.us_cnt", dut.us_cnt, 32'd250);

    // Single word stamped after 10 us, then popped
    do_reset();
    for (int i = 0; i < 40; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h12345678, 1'b0, 1'b0);
    chk_all("single_push", 32'h12345678, 32'h0000000A, 3'd1, 1'b0, 8'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk_all("single_hold", 32'h12345678, 32'h0000000A, 3'd1, 1'b0, 8'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk_all("single_pop", E, E, 3'd0, 1'b0, 8'd0);

    // Vector table
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(vt[i].v, vt[i].d, vt[i].r, vt[i].c);
      chk_all($sformatf("vec%0d", i), vt[i].ed, vt[i].et, vt[i].el, vt[i].eo, vt[i].edc);
    end

    // Drop counter saturation and clear/drop interaction
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 32'hEE, 1'b0, 1'b0);
    chk("sat.drop_cnt", 32'(drop_cnt), 32'd255);
    chk("sat.overflow", 32'(overflow), 32'd1);
    chk("sat.level", 32'(level), 32'd4);
    chk("sat.decPack", decPack, 32'hD0);
    cyc(1'b1, 32'hEF, 1'b0, 1'b1);
    chk("clrdrop.drop_cnt", 32'(drop_cnt), 32'd1);
    chk("clrdrop.overflow", 32'(overflow), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr.drop_cnt", 32'(drop_cnt), 32'd0);
    chk("clr.overflow", 32'(overflow), 32'd0);

    // Reset mid-stream at level 3
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("mid.level", 32'(level), 32'd3);
    chk("mid.decPack", decPack, 32'hD1);
    do_reset();
    chk_all("midrst", E, E, 3'd0, 1'b0, 8'd0);
    chk("midrst.us_cnt", dut.us_cnt, 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk_all("midrst_pop", E, E, 3'd0, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
